// File: rtl/zero_scan.sv
// zero_scan: finds the lowest (mode 0) or highest (mode 1) set bit of an
// operand by examining one CHUNK-bit slice per cycle, stopping early on the
// first nonzero slice. Valid/ready on both the operand and result sides.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | waiting for an operand; in_ready=1
// SCAN  | examining one chunk per cycle; busy=1
// DONE  | result held on nonzero/first_idx with out_valid=1 until taken

module zero_scan #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8,
  parameter int IDXW  = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] opA,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             nonzero,
  output logic [IDXW-1:0]  first_idx,
  output logic             busy
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CNTW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int BITW   = (CHUNK > 1) ? $clog2(CHUNK) : 1;

  // Refuse to elaborate an operand that does not split into whole chunks.
  if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
    $error("zero_scan: WIDTH must be a multiple of CHUNK");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q;
  logic [WIDTH-1:0]  op_q;
  logic              mode_q;
  logic [CNTW-1:0]   cnt_q;
  logic              nonzero_q;
  logic [IDXW-1:0]   first_idx_q;

  logic [CNTW-1:0]   chunk_sel;
  logic [CHUNK-1:0]  chunk_bits;
  logic [BITW-1:0]   bit_pos;
  logic              hit;
  logic              last_chunk;
  logic              nonzero_d;
  logic [IDXW-1:0]   first_idx_d;

  // The counter always counts chunks examined; mode 1 mirrors it so the
  // scan walks from the top chunk downward.
  always_comb begin
    chunk_sel = cnt_q;
    if (mode_q) begin
      chunk_sel = CNTW'(NCHUNK - 1) - cnt_q;
    end
  end

  // Select the chunk under examination this cycle.
  always_comb begin
    chunk_bits = '0;
    for (int k = 0; k < NCHUNK; k++) begin
      if (chunk_sel == CNTW'(k)) begin
        chunk_bits = op_q[k*CHUNK +: CHUNK];
      end
    end
  end

  // Priority-encode within the chunk: the last match written wins, so the
  // loop direction picks lowest (mode 0) or highest (mode 1) set bit.
  always_comb begin
    bit_pos = '0;
    if (mode_q) begin
      for (int i = 0; i < CHUNK; i++) begin
        if (chunk_bits[i]) begin
          bit_pos = BITW'(i);
        end
      end
    end else begin
      for (int i = CHUNK - 1; i >= 0; i--) begin
        if (chunk_bits[i]) begin
          bit_pos = BITW'(i);
        end
      end
    end
  end

  // Result candidates registered on the edge that enters DONE.
  always_comb begin
    hit         = |chunk_bits;
    last_chunk  = (cnt_q == CNTW'(NCHUNK - 1));
    nonzero_d   = hit;
    first_idx_d = '0;
    if (hit) begin
      first_idx_d = (IDXW'(chunk_sel) * IDXW'(CHUNK)) + IDXW'(bit_pos);
    end
  end

  // Control FSM with the operand latch, chunk counter and result registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      mode_q      <= 1'b0;
      cnt_q       <= '0;
      nonzero_q   <= 1'b0;
      first_idx_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            op_q    <= opA;
            mode_q  <= mode;
            cnt_q   <= '0;
            state_q <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (hit || last_chunk) begin
            nonzero_q   <= nonzero_d;
            first_idx_q <= first_idx_d;
            state_q     <= S_DONE;
          end else begin
            cnt_q <= cnt_q + CNTW'(1);
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q == S_SCAN);
  assign out_valid = (state_q == S_DONE);
  assign nonzero   = nonzero_q;
  assign first_idx = first_idx_q;

endmodule
